// File: rtl/ibex_rf_wr_arbiter_if.sv
// Register-file write arbiter bus: LSU, ID and PMC write sources,
// hazard lookup and the arbitrated RF write port.
interface ibex_rf_wr_arbiter_if;
  logic        lsu_we_i;
  logic [4:0]  lsu_waddr_i;
  logic [31:0] lsu_wdata_i;
  logic        id_we_i;
  logic [4:0]  id_waddr_i;
  logic [31:0] id_wdata_i;
  logic        id_ready_o;
  logic        pmc_valid_i;
  logic        pmc_ready_o;
  logic [4:0]  pmc_waddr_i;
  logic [31:0] pmc_wdata_i;
  logic [4:0]  rf_raddr_a_i;
  logic [4:0]  rf_raddr_b_i;
  logic [1:0]  pmc_hazard_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        pmc_pending_o;

  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  id_we_i, id_waddr_i, id_wdata_i,
    output id_ready_o,
    input  pmc_valid_i, pmc_waddr_i, pmc_wdata_i,
    output pmc_ready_o,
    input  rf_raddr_a_i, rf_raddr_b_i,
    output pmc_hazard_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    output pmc_pending_o
  );

  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output id_we_i, id_waddr_i, id_wdata_i,
    input  id_ready_o,
    output pmc_valid_i, pmc_waddr_i, pmc_wdata_i,
    input  pmc_ready_o,
    output rf_raddr_a_i, rf_raddr_b_i,
    input  pmc_hazard_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    input  pmc_pending_o
  );
endinterface

// File: rtl/ibex_rf_wr_arbiter.sv
// RF write-port arbiter: LSU > (promoted PMC) > ID > PMC FIFO head.
// Define IBEX_RF_ARB_STARVE_PROMOTE_EN to enable PMC starvation promotion.
module ibex_rf_wr_arbiter #(
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned StarveLimit = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ibex_rf_wr_arbiter_if.slave   bus
);

  localparam int unsigned AW = $clog2(FifoDepth);

  if (FifoDepth < 2 || FifoDepth > 16 ||
      (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("FifoDepth must be a power of two in 2..16");
  end
  if (StarveLimit < 1 || StarveLimit > 255) begin : g_bad_limit
    $error("StarveLimit must be in 1..255");
  end

  logic [4:0]  addr_q [FifoDepth];
  logic [31:0] data_q [FifoDepth];
  logic [AW:0] wptr_q, rptr_q, count;
  logic [AW-1:0] widx, ridx;
  logic empty, full, push, pop, promote;
  logic g_lsu, g_prom, g_id, g_pmc;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  assign widx  = wptr_q[AW-1:0];
  assign ridx  = rptr_q[AW-1:0];
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (widx == ridx);

  // x0 pushes complete the handshake but never occupy a slot
  assign push = bus.pmc_valid_i & ~full & (bus.pmc_waddr_i != 5'd0);
  assign pop  = g_prom | g_pmc;

`ifdef IBEX_RF_ARB_STARVE_PROMOTE_EN
  logic [7:0] starve_q;

  assign promote = ~empty & (starve_q == 8'(StarveLimit));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (pop || empty) begin
      starve_q <= '0;
    end else if (!promote) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    g_lsu  = 1'b0;
    g_prom = 1'b0;
    g_id   = 1'b0;
    g_pmc  = 1'b0;
    priority case (1'b1)
      bus.lsu_we_i: g_lsu  = 1'b1;
      promote:      g_prom = 1'b1;
      bus.id_we_i:  g_id   = 1'b1;
      !empty:       g_pmc  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    if (g_lsu) begin
      sel_addr = bus.lsu_waddr_i;
      sel_data = bus.lsu_wdata_i;
    end else if (g_id) begin
      sel_addr = bus.id_waddr_i;
      sel_data = bus.id_wdata_i;
    end else if (pop) begin
      sel_addr = addr_q[ridx];
      sel_data = data_q[ridx];
    end
  end

  assign bus.rf_we_o       = (sel_addr != 5'd0);
  assign bus.rf_waddr_o    = sel_addr;
  assign bus.rf_wdata_o    = sel_data;
  assign bus.id_ready_o    = ~bus.lsu_we_i & ~promote;
  assign bus.pmc_ready_o   = ~full;
  assign bus.pmc_pending_o = ~empty;

  // Slot i is live when its distance from the head is below occupancy
  always_comb begin
    bus.pmc_hazard_o = 2'b00;
    for (int i = 0; i < FifoDepth; i++) begin
      if ((AW+1)'(AW'(AW'(i) - ridx)) < count) begin
        if (bus.rf_raddr_a_i != 5'd0 && addr_q[i] == bus.rf_raddr_a_i)
          bus.pmc_hazard_o[0] = 1'b1;
        if (bus.rf_raddr_b_i != 5'd0 && addr_q[i] == bus.rf_raddr_b_i)
          bus.pmc_hazard_o[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[widx] <= bus.pmc_waddr_i;
      data_q[widx] <= bus.pmc_wdata_i;
    end
  end

  a_grant_onehot0: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    $onehot0({g_lsu, g_prom, g_id, g_pmc}));

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Self-checking bench for ibex_rf_wr_arbiter: queue-based model,
// directed scenarios with literal expectations, then random traffic.
module tb_ibex_rf_wr_arbiter;

  localparam int Depth = 4;
  localparam int Limit = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  ibex_rf_wr_arbiter_if bus ();

  ibex_rf_wr_arbiter #(
    .FifoDepth  (Depth),
    .StarveLimit(Limit)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   wait_c;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  logic        m_pop, m_push;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  task automatic idle();
    bus.lsu_we_i     = 1'b0;
    bus.lsu_waddr_i  = '0;
    bus.lsu_wdata_i  = '0;
    bus.id_we_i      = 1'b0;
    bus.id_waddr_i   = '0;
    bus.id_wdata_i   = '0;
    bus.pmc_valid_i  = 1'b0;
    bus.pmc_waddr_i  = '0;
    bus.pmc_wdata_i  = '0;
    bus.rf_raddr_a_i = '0;
    bus.rf_raddr_b_i = '0;
  endtask

  // Model: derive every output from the queue and the priority rules.
  task automatic settle();
    logic        full, prom, e_we, e_idr;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [1:0]  eh;
    int          src;
    #1;
    full  = (q.size() == Depth);
    prom  = 1'b0;
`ifdef IBEX_RF_ARB_STARVE_PROMOTE_EN
    prom  = (q.size() > 0) && (wait_c >= Limit);
`endif
    e_idr = !bus.lsu_we_i && !prom;
    if (bus.lsu_we_i) src = 1;
    else if (prom) src = 2;
    else if (bus.id_we_i) src = 3;
    else if (q.size() > 0) src = 2;
    else src = 0;
    ea = '0;
    ed = '0;
    case (src)
      1: begin ea = bus.lsu_waddr_i; ed = bus.lsu_wdata_i; end
      2: begin ea = q[0].a; ed = q[0].d; end
      3: begin ea = bus.id_waddr_i; ed = bus.id_wdata_i; end
      default: ;
    endcase
    e_we = (src != 0) && (ea != 0);
    eh = 2'b00;
    foreach (q[i]) begin
      if (bus.rf_raddr_a_i != 0 && q[i].a == bus.rf_raddr_a_i) eh[0] = 1'b1;
      if (bus.rf_raddr_b_i != 0 && q[i].a == bus.rf_raddr_b_i) eh[1] = 1'b1;
    end
    m_pop  = (src == 2);
    m_push = bus.pmc_valid_i && !full && (bus.pmc_waddr_i != 0);
    m_pa   = bus.pmc_waddr_i;
    m_pd   = bus.pmc_wdata_i;
    chk("model",
        64'({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.id_ready_o,
             bus.pmc_ready_o, bus.pmc_pending_o, bus.pmc_hazard_o}),
        64'({e_we, ea, ed, e_idr, !full, q.size() > 0, eh}));
  endtask

  task automatic tick();
    logic was_empty;
    @(posedge clk_i);
    was_empty = (q.size() == 0);
    if (m_pop) void'(q.pop_front());
    if (m_push) q.push_back('{a: m_pa, d: m_pd});
    if (m_pop || was_empty) wait_c = 0;
    else if (wait_c < Limit) wait_c++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    q.delete();
    wait_c = 0;
    settle();
    chk("rst_pending", 64'(bus.pmc_pending_o), 64'd0);
    chk("rst_ready", 64'(bus.pmc_ready_o), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    idle();
    rst_ni = 1'b1;
    wait_c = 0;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    settle();
    chk("reset_pmc_ready", 64'(bus.pmc_ready_o), 64'd1);
    chk("reset_id_ready", 64'(bus.id_ready_o), 64'd1);
    chk("reset_pending", 64'(bus.pmc_pending_o), 64'd0);
    chk("reset_hazard", 64'(bus.pmc_hazard_o), 64'd0);
    chk("reset_rf_we", 64'(bus.rf_we_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // idle after reset
    settle();
    chk("idle_rf_we", 64'(bus.rf_we_o), 64'd0);
    chk("idle_id_ready", 64'(bus.id_ready_o), 64'd1);
    tick();

    // LSU beats ID, ID follows next cycle
    bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = 5'd5; bus.lsu_wdata_i = 32'hAA;
    bus.id_we_i  = 1'b1; bus.id_waddr_i  = 5'd6; bus.id_wdata_i  = 32'hBB;
    settle();
    chk("lsu_win_addr", 64'(bus.rf_waddr_o), 64'd5);
    chk("lsu_win_data", 64'(bus.rf_wdata_o), 64'hAA);
    chk("lsu_win_idrdy", 64'(bus.id_ready_o), 64'd0);
    tick();
    bus.lsu_we_i = 1'b0;
    settle();
    chk("id_next_addr", 64'(bus.rf_waddr_o), 64'd6);
    chk("id_next_data", 64'(bus.rf_wdata_o), 64'hBB);
    chk("id_next_idrdy", 64'(bus.id_ready_o), 64'd1);
    tick();
    idle();

    // single push drains the next cycle
    bus.pmc_valid_i = 1'b1; bus.pmc_waddr_i = 5'd9; bus.pmc_wdata_i = 32'h99;
    settle();
    chk("no_bypass", 64'(bus.rf_we_o), 64'd0);
    tick();
    bus.pmc_valid_i = 1'b0;
    settle();
    chk("drain_next", 64'({bus.rf_we_o, bus.rf_waddr_o}), 64'({1'b1, 5'd9}));
    tick();

    // hazard on port a until pop cycle inclusive
    bus.pmc_valid_i = 1'b1; bus.pmc_waddr_i = 5'd7; bus.pmc_wdata_i = 32'h77;
    bus.rf_raddr_a_i = 5'd7; bus.rf_raddr_b_i = 5'd0;
    settle();
    chk("haz_before", 64'(bus.pmc_hazard_o), 64'd0);
    tick();
    bus.pmc_valid_i = 1'b0;
    bus.id_we_i = 1'b1; bus.id_waddr_i = 5'd0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("haz_held", 64'(bus.pmc_hazard_o), 64'b01);
      tick();
    end
    bus.id_we_i = 1'b0;
    settle();
    chk("haz_pop", 64'({bus.pmc_hazard_o, bus.rf_waddr_o}), 64'({2'b01, 5'd7}));
    tick();
    settle();
    chk("haz_clear", 64'(bus.pmc_hazard_o), 64'd0);
    tick();
    idle();

    // fill to full while ID holds the port, then drain in order
    bus.id_we_i = 1'b1; bus.id_waddr_i = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      bus.pmc_valid_i = 1'b1;
      bus.pmc_waddr_i = 5'(i);
      bus.pmc_wdata_i = 32'h100 + 32'(i);
      settle();
      chk("fill_ready", 64'(bus.pmc_ready_o), 64'd1);
      tick();
    end
    bus.pmc_waddr_i = 5'd20;
    settle();
    chk("full_ready", 64'(bus.pmc_ready_o), 64'd0);
    tick();
    bus.pmc_valid_i = 1'b0; bus.id_we_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("drain_order",
          64'({bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o}),
          64'({1'b1, 5'(i), 32'h100 + 32'(i)}));
      tick();
    end
    settle();
    chk("drained", 64'(bus.pmc_pending_o), 64'd0);
    tick();

    // x0 push completes but stores nothing
    bus.pmc_valid_i = 1'b1; bus.pmc_waddr_i = 5'd0; bus.pmc_wdata_i = 32'hFF;
    settle();
    chk("x0_ready", 64'(bus.pmc_ready_o), 64'd1);
    tick();
    bus.pmc_valid_i = 1'b0;
    settle();
    chk("x0_pending", 64'({bus.pmc_pending_o, bus.rf_we_o}), 64'd0);
    tick();

    // starvation behaviour under continuous ID writes
    bus.pmc_valid_i = 1'b1; bus.pmc_waddr_i = 5'd12; bus.pmc_wdata_i = 32'h12;
    settle();
    tick();
    bus.pmc_valid_i = 1'b0;
    bus.id_we_i = 1'b1; bus.id_waddr_i = 5'd3; bus.id_wdata_i = 32'h33;
`ifdef IBEX_RF_ARB_STARVE_PROMOTE_EN
    for (int c = 1; c <= 9; c++) begin
      settle();
      if (c < 9)
        chk("starve_wait", 64'({bus.rf_waddr_o, bus.id_ready_o}), 64'({5'd3, 1'b1}));
      else
        chk("starve_promo", 64'({bus.rf_waddr_o, bus.id_ready_o}), 64'({5'd12, 1'b0}));
      tick();
    end
`else
    for (int c = 1; c <= 12; c++) begin
      settle();
      chk("starve_never", 64'(bus.rf_waddr_o), 64'd3);
      tick();
    end
    bus.id_we_i = 1'b0;
    settle();
    chk("starve_release", 64'(bus.rf_waddr_o), 64'd12);
    tick();
`endif
    idle();

    // reset mid-operation discards buffered writes
    bus.id_we_i = 1'b1; bus.id_waddr_i = 5'd0;
    for (int i = 0; i < 2; i++) begin
      bus.pmc_valid_i = 1'b1;
      bus.pmc_waddr_i = 5'd13 + 5'(i);
      bus.pmc_wdata_i = 32'hD0 + 32'(i);
      settle();
      tick();
    end
    do_reset();
    settle();
    chk("post_rst_we", 64'({bus.rf_we_o, bus.pmc_pending_o}), 64'd0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        bus.lsu_we_i     = ($urandom_range(0, 3) == 0);
        bus.lsu_waddr_i  = 5'($urandom_range(0, 7));
        bus.lsu_wdata_i  = $urandom;
        bus.id_we_i      = ((n / 200) % 2 == 1) ? ($urandom_range(0, 19) != 0)
                                                : ($urandom_range(0, 9) < 6);
        bus.id_waddr_i   = 5'($urandom_range(0, 31));
        bus.id_wdata_i   = $urandom;
        bus.pmc_valid_i  = ($urandom_range(0, 1) == 1);
        bus.pmc_waddr_i  = 5'($urandom_range(0, 7));
        bus.pmc_wdata_i  = $urandom;
        bus.rf_raddr_a_i = 5'($urandom_range(0, 7));
        bus.rf_raddr_b_i = 5'($urandom_range(0, 7));
      end
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
